// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle multiply/divide unit with HI/LO registers (clk, rst, start, op, ReadData1, ReadData2 -> busy, done, hi, lo)
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t st;
  logic [CNT_W-1:0] cnt;
  logic is_div, s1, s2, n1, n2, ge;
  logic [WIDTH-1:0] acc, lw, b, mag1, mag2, diff, quo_f, rem_f;
  logic [WIDTH:0] sum, t;
  logic [2*WIDTH-1:0] prod_f;
  always_comb begin
    n1 = ~op[0] & ReadData1[WIDTH-1];
    n2 = ~op[0] & ReadData2[WIDTH-1];
    mag1 = n1 ? -ReadData1 : ReadData1;
    mag2 = n2 ? -ReadData2 : ReadData2;
    sum = {1'b0, acc} + {1'b0, lw[0] ? b : '0};
    t = {acc, lw[WIDTH-1]};
    ge = t >= {1'b0, b};
    diff = t[WIDTH-1:0] - b;
    prod_f = (s1 ^ s2) ? -{acc, lw} : {acc, lw};
    quo_f = (s1 ^ s2) ? -lw : lw;
    rem_f = s1 ? -acc : acc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      is_div <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      acc <= '0;
      lw <= '0;
      b <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          if (!op[2]) begin
            st <= CALC;
            busy <= 1'b1;
            cnt <= '0;
            is_div <= op[1];
            s1 <= n1;
            s2 <= n2;
            acc <= '0;
            lw <= op[1] ? mag1 : mag2;
            b <= op[1] ? mag2 : mag1;
          end else if (op[1:0] == 2'b00) hi <= ReadData1;
          else if (op[1:0] == 2'b01) lo <= ReadData1;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (&cnt) st <= FIX;
          if (is_div) begin
            acc <= ge ? diff : t[WIDTH-1:0];
            lw <= {lw[WIDTH-2:0], ge};
          end else {acc, lw} <= {sum, lw[WIDTH-1:1]};
        end
        FIX: begin
          st <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          if (!is_div) {hi, lo} <= prod_f;
          else if (b != '0) begin
            hi <= rem_f;
            lo <= quo_f;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers.
- Sits in EX beside the single-cycle ALU. It consumes the same ReadData1/ReadData2 operands and handles the operations the ALU cannot finish in one cycle: mult, multu, div, divu, mthi, mtlo.
- Drives busy so the hazard unit stalls a following mult/div/mfhi/mflo.
- hi/lo outputs feed the mfhi/mflo path.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; 2^CNT_W must equal WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request strobe; sampled on the rising edge.
- op  in  3  operation select: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 are no-ops.
- ReadData1  in  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source).
- ReadData2  in  WIDTH  rt operand (divisor / multiplier).
- busy  out  1  high while a mult/div is in progress.
- done  out  1  one-cycle pulse when HI/LO are updated by mult/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, active-high):
  - busy=0, done=0, hi=0, lo=0.
  - FSM returns to IDLE and the counter clears.
  - An operation in flight is aborted with no HI/LO write.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1:
  - op=100: hi<=ReadData1 at the next edge.
  - op=101: lo<=ReadData1 at the next edge.
  - mthi/mtlo never raise busy or done.
  - op=000..011: latch op, operand magnitudes (signed ops take the absolute value) and both operand signs. Go to CALC, busy=1 from this edge on, counter=0.
  - op=110/111: ignored.
- Iteration, one per cycle:
  - Multiply: shift-add over the 64-bit {acc,mplier}.
  - Divide: restoring shift-subtract over the 64-bit {rem,quot}.
  - Counter increments each cycle. After iteration 31 (32 CALC cycles) go to FIX.
- FIX (single cycle):
  - Apply signs. Product is negated when sign1^sign2 for mult. Quotient is negated when sign1^sign2 for div; remainder takes the dividend sign.
  - Write hi/lo: mult gives hi=product[63:32], lo=product[31:0]; div gives lo=quotient, hi=remainder.
  - Return to IDLE. busy=0 and done=1 for exactly one cycle after the FIX edge.
- Latency: 34 edges from accept to HI/LO valid (1 accept + 32 CALC + 1 FIX). busy is high for 33 cycles.
- hi/lo keep their old values during CALC; there are no partial writes.
- start while busy=1 (any op, including mthi/mtlo) is ignored. The pipeline must stall; the unit does not queue.
- Divide by zero:
  - Completes with normal latency and done pulses.
  - hi and lo are left unchanged.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (magnitude wrap, no trap).
- Operands are captured at accept. Changes on ReadData1/2 during busy have no effect.
- done and the FIX edge do not block a new start. A start in the cycle where done=1 is accepted (back-to-back).

Test Plan:
- rst high mid-CALC (cycle 10 of a mult) -> busy=0, done=0, hi=lo=0 asynchronously. No done pulse afterwards; the next mult runs a full 34 edges.
- multu 0xFFFFFFFF x 0xFFFFFFFF:
  - busy high for 33 cycles.
  - done pulses once.
  - hi=0xFFFFFFFE, lo=0x00000001.
- mult -7 (0xFFFFFFF9) x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- div -7 / 2:
  - lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - divu 7/2 gives lo=3, hi=1.
  - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero after mthi 0x1234, mtlo 0x5678, then divu 9/0:
  - mthi/mtlo update in 1 cycle with no busy.
  - Divide: done pulses after 34 edges; hi=0x1234, lo=0x5678 unchanged.
- mult accepted, then start with mtlo 0xAAAA at cycle 5 and another mult at cycle 20 -> both ignored, lo unaffected. A divu issued in the done cycle is accepted, busy stays 0 for only that one cycle, and the result is correct.
